// File: rtl/pifo_calendar_pkg.sv
// Shared types, constants and the rank ordering helper for the PIFO calendar.
// Element layout and cell mux encodings are common to the top and each cell.
package pifo_calendar_pkg;

  localparam int DEF_RANK_WIDTH = 18;
  localparam int DEF_DATA_WIDTH = 12;

  typedef struct packed {
    logic                      valid;
    logic [DEF_RANK_WIDTH-1:0] rank;
    logic [DEF_DATA_WIDTH-1:0] data;
  } elem_t;

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_NEW  = 2'd1;
  localparam logic [1:0] SEL_PREV = 2'd2;
  localparam logic [1:0] SEL_NEXT = 2'd3;

  // Ranks arrive zero-extended to 64 bits; in wrap mode the sign of the
  // difference modulo 2^width decides, so ranks may roll over freely.
  function automatic logic rank_before(input logic [63:0] a, input logic [63:0] b,
                                       input int unsigned width, input logic wrap);
    logic [63:0] diff;
    diff = a - b;
    if (wrap) begin
      return ((diff >> (width - 1)) & 64'd1) != 64'd0;
    end
    return a < b;
  endfunction

endpackage

// File: rtl/pifo_calendar_cell_v2.sv
// One calendar cell: holds, loads the new element, or shifts from a neighbour.
// Selection depends only on the local at-or-after-insert-point bits and pop/insert accepts.
module pifo_calendar_cell_v2
  import pifo_calendar_pkg::*;
#(
  parameter int RANK_WIDTH = 18,
  parameter int DATA_WIDTH = 12,
  parameter bit IS_HEAD    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  pa_i,
  input  logic                  ia_i,
  input  logic                  atp_i,
  input  logic                  atp_prev_i,
  input  logic                  atp_next_i,
  input  logic [RANK_WIDTH-1:0] new_rank_i,
  input  logic [DATA_WIDTH-1:0] new_data_i,
  input  logic                  prev_vld_i,
  input  logic [RANK_WIDTH-1:0] prev_rank_i,
  input  logic [DATA_WIDTH-1:0] prev_data_i,
  input  logic                  next_vld_i,
  input  logic [RANK_WIDTH-1:0] next_rank_i,
  input  logic [DATA_WIDTH-1:0] next_data_i,
  output logic                  vld_o,
  output logic [RANK_WIDTH-1:0] rank_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [1:0]            sel;
  logic                  vld_q, vld_d;
  logic [RANK_WIDTH-1:0] rank_q, rank_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // On pop+insert the new element lands one slot earlier than its insert point,
  // because everything ahead of it moves toward the head in the same cycle.
  always_comb begin
    sel = SEL_HOLD;
    if (pa_i && ia_i) begin
      if (!(atp_i && !IS_HEAD)) begin
        sel = atp_next_i ? SEL_NEW : SEL_NEXT;
      end
    end else if (pa_i) begin
      sel = SEL_NEXT;
    end else if (ia_i) begin
      if (atp_prev_i) begin
        sel = SEL_PREV;
      end else if (atp_i) begin
        sel = SEL_NEW;
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    rank_d = rank_q;
    data_d = data_q;
    case (sel)
      SEL_NEW:  begin vld_d = 1'b1;       rank_d = new_rank_i;  data_d = new_data_i;  end
      SEL_PREV: begin vld_d = prev_vld_i; rank_d = prev_rank_i; data_d = prev_data_i; end
      SEL_NEXT: begin vld_d = next_vld_i; rank_d = next_rank_i; data_d = next_data_i; end
      default:  ;
    endcase
    if (flush_i) begin
      vld_d  = 1'b0;
      rank_d = '0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      rank_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      rank_q <= rank_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign rank_o = rank_q;
  assign data_o = data_q;

endmodule

// File: rtl/pifo_calendar_v2.sv
// Shift-register PIFO calendar: rank-ordered, FIFO among equal ranks, pop result one cycle after request.
// Full queue either back-pressures inserts (ready falls unless a pop frees a slot) or evicts the tail.
module pifo_calendar_v2
  import pifo_calendar_pkg::*;
#(
  parameter int DEPTH        = 64,
  parameter int COUNT_WIDTH  = 7,
  parameter int RANK_WIDTH   = 18,
  parameter int DATA_WIDTH   = 12,
  parameter int WRAP_COMPARE = 1,
  parameter int FULL_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   s_insert_valid,
  output logic                   s_insert_ready,
  input  logic [RANK_WIDTH-1:0]  s_insert_rank,
  input  logic [DATA_WIDTH-1:0]  s_insert_data,
  input  logic                   s_pop_req,
  output logic                   m_pop_valid,
  output logic [RANK_WIDTH-1:0]  m_pop_rank,
  output logic [DATA_WIDTH-1:0]  m_pop_data,
  output logic                   m_head_valid,
  output logic [RANK_WIDTH-1:0]  m_head_rank,
  output logic [DATA_WIDTH-1:0]  m_head_data,
  output logic                   m_drop_valid,
  output logic [DATA_WIDTH-1:0]  m_drop_data,
  output logic [COUNT_WIDTH-1:0] m_count,
  output logic                   m_full,
  output logic                   m_empty
);

  localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(DEPTH);

  logic [DEPTH-1:0]      cell_vld;
  logic [RANK_WIDTH-1:0] cell_rank [DEPTH];
  logic [DATA_WIDTH-1:0] cell_dat  [DEPTH];
  logic [DEPTH-1:0]      gt;
  logic [DEPTH-1:0]      atp;
  logic                  pa, ia, full, empty;

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   pop_vld_q;
  logic [RANK_WIDTH-1:0]  pop_rank_q;
  logic [DATA_WIDTH-1:0]  pop_dat_q;
  logic                   drop_vld_q, drop_vld_d;
  logic [DATA_WIDTH-1:0]  drop_dat_q, drop_dat_d;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign pa    = s_pop_req && !empty && !flush;
  assign s_insert_ready = (FULL_MODE != 0) ? 1'b1 : (!full || pa);
  assign ia    = s_insert_valid && s_insert_ready && !flush;

  // atp[i]: cell i sits at or after the insert point p (prefix OR of gt).
  always_comb begin
    logic run;
    run = 1'b0;
    gt  = '0;
    atp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      gt[i]  = !cell_vld[i] ||
               rank_before(64'(s_insert_rank), 64'(cell_rank[i]), RANK_WIDTH, WRAP_COMPARE != 0);
      run    = run | gt[i];
      atp[i] = run;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic                  atp_prev, atp_next, prev_vld, next_vld;
    logic [RANK_WIDTH-1:0] prev_rank, next_rank;
    logic [DATA_WIDTH-1:0] prev_dat, next_dat;

    if (i == 0) begin : g_head
      assign atp_prev  = 1'b0;
      assign prev_vld  = 1'b0;
      assign prev_rank = '0;
      assign prev_dat  = '0;
    end else begin : g_body
      assign atp_prev  = atp[i-1];
      assign prev_vld  = cell_vld[i-1];
      assign prev_rank = cell_rank[i-1];
      assign prev_dat  = cell_dat[i-1];
    end

    // Beyond the tail everything counts as "at or after p" and reads as empty.
    if (i == DEPTH - 1) begin : g_tail
      assign atp_next  = 1'b1;
      assign next_vld  = 1'b0;
      assign next_rank = '0;
      assign next_dat  = '0;
    end else begin : g_inner
      assign atp_next  = atp[i+1];
      assign next_vld  = cell_vld[i+1];
      assign next_rank = cell_rank[i+1];
      assign next_dat  = cell_dat[i+1];
    end

    pifo_calendar_cell_v2 #(
      .RANK_WIDTH(RANK_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .IS_HEAD   (i == 0)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .pa_i       (pa),
      .ia_i       (ia),
      .atp_i      (atp[i]),
      .atp_prev_i (atp_prev),
      .atp_next_i (atp_next),
      .new_rank_i (s_insert_rank),
      .new_data_i (s_insert_data),
      .prev_vld_i (prev_vld),
      .prev_rank_i(prev_rank),
      .prev_data_i(prev_dat),
      .next_vld_i (next_vld),
      .next_rank_i(next_rank),
      .next_data_i(next_dat),
      .vld_o      (cell_vld[i]),
      .rank_o     (cell_rank[i]),
      .data_o     (cell_dat[i])
    );
  end

  // A drop only happens on an insert into a full queue without a pop (evict mode).
  always_comb begin
    drop_vld_d = ia && !pa && full;
    drop_dat_d = atp[DEPTH-1] ? cell_dat[DEPTH-1] : s_insert_data;
    count_d    = count_q;
    if (flush) begin
      count_d = '0;
    end else if (ia && !pa && !full) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end else if (pa && !ia) begin
      count_d = count_q - COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      pop_vld_q  <= 1'b0;
      pop_rank_q <= '0;
      pop_dat_q  <= '0;
      drop_vld_q <= 1'b0;
      drop_dat_q <= '0;
    end else begin
      count_q    <= count_d;
      pop_vld_q  <= pa;
      drop_vld_q <= drop_vld_d;
      if (pa) begin
        pop_rank_q <= cell_rank[0];
        pop_dat_q  <= cell_dat[0];
      end
      if (drop_vld_d) begin
        drop_dat_q <= drop_dat_d;
      end
    end
  end

  assign m_pop_valid  = pop_vld_q;
  assign m_pop_rank   = pop_rank_q;
  assign m_pop_data   = pop_dat_q;
  assign m_drop_valid = drop_vld_q;
  assign m_drop_data  = drop_dat_q;
  assign m_head_valid = cell_vld[0];
  assign m_head_rank  = cell_rank[0];
  assign m_head_data  = cell_dat[0];
  assign m_count      = count_q;
  assign m_full       = full;
  assign m_empty      = empty;

endmodule

// File: tb/tb_pifo_calendar_v2.sv
// Two small calendars (wrap/backpressure and plain/evict) share one stimulus stream
// and are compared each cycle against a list-based reference model.
module tb_pifo_calendar_v2;

  localparam int D  = 4;
  localparam int RW = 4;
  localparam int DW = 12;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic ins_v = 1'b0;
  logic pop = 1'b0;
  logic [RW-1:0] ins_rank = '0;
  logic [DW-1:0] ins_dat = '0;

  logic [1:0]    rdy, pop_vld, head_vld, drop_vld, full, empty;
  logic [RW-1:0] pop_rank [2];
  logic [RW-1:0] head_rank [2];
  logic [DW-1:0] pop_dat [2];
  logic [DW-1:0] head_dat [2];
  logic [DW-1:0] drop_dat [2];
  logic [CW-1:0] count [2];

  always #5 clk = ~clk;

  pifo_calendar_v2 #(.DEPTH(D), .COUNT_WIDTH(CW), .RANK_WIDTH(RW), .DATA_WIDTH(DW),
                     .WRAP_COMPARE(1), .FULL_MODE(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_insert_valid(ins_v), .s_insert_ready(rdy[0]), .s_insert_rank(ins_rank), .s_insert_data(ins_dat),
    .s_pop_req(pop), .m_pop_valid(pop_vld[0]), .m_pop_rank(pop_rank[0]), .m_pop_data(pop_dat[0]),
    .m_head_valid(head_vld[0]), .m_head_rank(head_rank[0]), .m_head_data(head_dat[0]),
    .m_drop_valid(drop_vld[0]), .m_drop_data(drop_dat[0]),
    .m_count(count[0]), .m_full(full[0]), .m_empty(empty[0]));

  pifo_calendar_v2 #(.DEPTH(D), .COUNT_WIDTH(CW), .RANK_WIDTH(RW), .DATA_WIDTH(DW),
                     .WRAP_COMPARE(0), .FULL_MODE(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_insert_valid(ins_v), .s_insert_ready(rdy[1]), .s_insert_rank(ins_rank), .s_insert_data(ins_dat),
    .s_pop_req(pop), .m_pop_valid(pop_vld[1]), .m_pop_rank(pop_rank[1]), .m_pop_data(pop_dat[1]),
    .m_head_valid(head_vld[1]), .m_head_rank(head_rank[1]), .m_head_data(head_dat[1]),
    .m_drop_valid(drop_vld[1]), .m_drop_data(drop_dat[1]),
    .m_count(count[1]), .m_full(full[1]), .m_empty(empty[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per instance an ordered list of (rank, data), head at index 0.
  int  m_rank [2][D];
  int  m_dat  [2][D];
  int  m_n    [2];
  bit  e_pop_vld [2];
  int  e_pop_rank [2];
  int  e_pop_dat [2];
  bit  e_drop_vld [2];
  int  e_drop_dat [2];

  function automatic bit before_m(int a, int b, bit wrap);
    if (wrap) return ((a - b) & 15) >= 8;
    return a < b;
  endfunction

  task automatic m_insert(int k, int pos, int r, int d);
    for (int i = m_n[k]; i > pos; i--) begin
      m_rank[k][i] = m_rank[k][i-1];
      m_dat[k][i]  = m_dat[k][i-1];
    end
    m_rank[k][pos] = r;
    m_dat[k][pos]  = d;
    m_n[k]++;
  endtask

  task automatic m_pop_head(int k);
    for (int i = 0; i < m_n[k] - 1; i++) begin
      m_rank[k][i] = m_rank[k][i+1];
      m_dat[k][i]  = m_dat[k][i+1];
    end
    m_n[k]--;
  endtask

  task automatic m_clear();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0;
      e_pop_vld[k] = 0;
      e_drop_vld[k] = 0;
    end
  endtask

  task automatic m_cycle(input int k, input bit wrap, input bit evict, output bit rdy_m);
    bit is_full, pa, ia;
    int p, r, d;
    r = int'(ins_rank);
    d = int'(ins_dat);
    is_full = (m_n[k] == D);
    pa = pop && (m_n[k] > 0) && !flush;
    rdy_m = evict || !is_full || pa;
    ia = ins_v && rdy_m && !flush;
    e_pop_vld[k]  = pa;
    e_drop_vld[k] = 0;
    if (flush) begin
      m_n[k] = 0;
      return;
    end
    p = D;
    for (int i = D - 1; i >= 0; i--)
      if (i >= m_n[k] || before_m(r, m_rank[k][i], wrap)) p = i;
    if (pa) begin
      e_pop_rank[k] = m_rank[k][0];
      e_pop_dat[k]  = m_dat[k][0];
      m_pop_head(k);
    end
    if (ia) begin
      if (pa) begin
        m_insert(k, (p > 0) ? p - 1 : 0, r, d);
      end else if (!is_full) begin
        m_insert(k, p, r, d);
      end else begin
        e_drop_vld[k] = 1;
        if (p < D) begin
          e_drop_dat[k] = m_dat[k][D-1];
          m_n[k]--;
          m_insert(k, p, r, d);
        end else begin
          e_drop_dat[k] = d;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("pop_vld%0d", k), 32'(pop_vld[k]), 32'(e_pop_vld[k]));
      if (e_pop_vld[k]) begin
        check_eq($sformatf("pop_rank%0d", k), 32'(pop_rank[k]), e_pop_rank[k]);
        check_eq($sformatf("pop_dat%0d", k), 32'(pop_dat[k]), e_pop_dat[k]);
      end
      check_eq($sformatf("drop_vld%0d", k), 32'(drop_vld[k]), 32'(e_drop_vld[k]));
      if (e_drop_vld[k]) check_eq($sformatf("drop_dat%0d", k), 32'(drop_dat[k]), e_drop_dat[k]);
      check_eq($sformatf("count%0d", k), 32'(count[k]), m_n[k]);
      check_eq($sformatf("full%0d", k), 32'(full[k]), 32'(m_n[k] == D));
      check_eq($sformatf("empty%0d", k), 32'(empty[k]), 32'(m_n[k] == 0));
      check_eq($sformatf("head_vld%0d", k), 32'(head_vld[k]), 32'(m_n[k] > 0));
      if (m_n[k] > 0) begin
        check_eq($sformatf("head_rank%0d", k), 32'(head_rank[k]), m_rank[k][0]);
        check_eq($sformatf("head_dat%0d", k), 32'(head_dat[k]), m_dat[k][0]);
      end
    end
  endtask

  // Called just after a rising edge: drive inputs, check ready mid-cycle, check state after the edge.
  task automatic cyc(input bit iv, input int r, input int d, input bit pv, input bit fl);
    bit rdy_m;
    ins_v = iv;
    ins_rank = RW'(r);
    ins_dat = DW'(d);
    pop = pv;
    flush = fl;
    #3;
    for (int k = 0; k < 2; k++) begin
      m_cycle(k, k == 0, k == 1, rdy_m);
      check_eq($sformatf("ready%0d", k), 32'(rdy[k]), 32'(rdy_m));
    end
    @(posedge clk);
    #1;
    ins_v = 1'b0;
    pop = 1'b0;
    flush = 1'b0;
    check_outputs();
  endtask

  int pop_seq_dat [4] = '{'hB, 'hD, 'hA, 'hC};
  int pop_seq_rank[4] = '{2, 2, 5, 9};

  initial begin
    m_clear();
    #2;
    check_outputs();
    check_eq("rst_pop_rank", 32'(pop_rank[0]), 0);
    check_eq("rst_drop_dat", 32'(drop_dat[1]), 0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Rank ordering with FIFO tie-break
    cyc(1, 5, 'hA, 0, 0);
    cyc(1, 2, 'hB, 0, 0);
    cyc(1, 9, 'hC, 0, 0);
    cyc(1, 2, 'hD, 0, 0);
    check_eq("head_rank_B", 32'(head_rank[0]), 2);
    check_eq("head_dat_B", 32'(head_dat[0]), 'hB);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 0);
      check_eq("seq_pop_vld", 32'(pop_vld[0]), 1);
      check_eq("seq_pop_dat", 32'(pop_dat[0]), pop_seq_dat[i]);
      check_eq("seq_pop_rank", 32'(pop_rank[1]), pop_seq_rank[i]);
    end
    cyc(0, 0, 0, 1, 0);
    check_eq("pop_empty_no_pulse", 32'(pop_vld[0]), 0);

    // Simultaneous pop and insert
    cyc(1, 3, 'h31, 0, 0);
    cyc(1, 7, 'h71, 0, 0);
    cyc(1, 1, 'h11, 1, 0);
    check_eq("pi_pop_rank", 32'(pop_rank[0]), 3);
    check_eq("pi_head_rank", 32'(head_rank[0]), 1);
    check_eq("pi_count", 32'(count[0]), 2);
    cyc(1, 8, 'h81, 1, 0);
    check_eq("pi2_head_rank", 32'(head_rank[0]), 7);
    cyc(0, 0, 0, 0, 1);

    // Full queue: backpressure (u0) and evict/drop (u1)
    for (int r = 1; r <= 4; r++) cyc(1, r, 'h100 + r, 0, 0);
    check_eq("full_u0", 32'(full[0]), 1);
    cyc(1, 0, 'h1F0, 0, 0);
    check_eq("evict_drop_dat", 32'(drop_dat[1]), 'h104);
    check_eq("bp_count", 32'(count[0]), 4);
    cyc(1, 9, 'h109, 0, 0);
    check_eq("drop_new_dat", 32'(drop_dat[1]), 'h109);
    cyc(1, 5, 'h105, 1, 0);
    check_eq("full_pop_ins_head", 32'(head_rank[0]), 2);
    cyc(0, 0, 0, 0, 1);

    // Wrap-aware versus plain compare
    cyc(1, 14, 'hE, 0, 0);
    cyc(1, 1, 'h1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check_eq("wrap_first", 32'(pop_rank[0]), 14);
    check_eq("plain_first", 32'(pop_rank[1]), 1);
    cyc(0, 0, 0, 1, 0);
    check_eq("wrap_second", 32'(pop_rank[0]), 1);
    check_eq("plain_second", 32'(pop_rank[1]), 14);

    // Flush overriding pop and insert
    for (int i = 0; i < 3; i++) cyc(1, i + 4, 'h40 + i, 0, 0);
    cyc(1, 3, 'h33, 1, 1);
    check_eq("flush_count", 32'(count[0]), 0);
    check_eq("flush_empty", 32'(empty[1]), 1);

    // Asynchronous reset between edges
    cyc(1, 6, 'h66, 0, 0);
    cyc(0, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    m_clear();
    check_eq("arst_pop_vld", 32'(pop_vld[0]), 0);
    check_eq("arst_count", 32'(count[0]), 0);
    check_outputs();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 60, $urandom_range(0, 15), $urandom_range(0, 4095),
          $urandom_range(0, 99) < 45, $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
